// File: rtl/f_pc_sequencer.sv
// ============================================================================
// f_pc_sequencer : F-stage PC register with BOOT/RUN/STALL control, redirect
//                  on exception entry or eret, fetch address checking and
//                  fetch/stall performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module f_pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PC_LO      = 32'h0000_3000,
  parameter logic [31:0] PC_HI      = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] F_PC,
  output logic        fetch_valid,
  output logic        F_exc_adel,
  output logic        redirect,
  output logic [15:0] stall_cnt,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redir_q, redir_d;
  logic [15:0] scnt_q, scnt_d;
  logic [31:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
      scnt_q  <= 16'd0;
      fcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = 1'b0;
    scnt_d  = scnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        // A redirect overrides stall, so the cycle still counts as a fetch.
        if (req) begin
          pc_d    = HANDLER_PC;
          redir_d = 1'b1;
          state_d = S_RUN;
          fcnt_d  = fcnt_q + 32'd1;
        end else if (eret) begin
          pc_d    = epc;
          redir_d = 1'b1;
          state_d = S_RUN;
          fcnt_d  = fcnt_q + 32'd1;
        end else if (stall) begin
          state_d = S_STALL;
          if (scnt_q != 16'hffff) scnt_d = scnt_q + 16'd1;
        end else begin
          pc_d    = npc_in;
          state_d = S_RUN;
          fcnt_d  = fcnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign F_PC        = pc_q;
  assign fetch_valid = (state_q != S_BOOT);
  assign redirect    = redir_q;
  assign stall_cnt   = scnt_q;
  assign fetch_cnt   = fcnt_q;
  assign F_exc_adel  = fetch_valid &&
                       ((pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI));

endmodule

`default_nettype wire

// File: tb/tb_f_pc_sequencer.sv
// ============================================================================
// tb_f_pc_sequencer : directed and randomized checks of f_pc_sequencer
//                     against a behavioural reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_f_pc_sequencer;

  localparam logic [31:0] C_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] C_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] C_PC_LO      = 32'h0000_3000;
  localparam logic [31:0] C_PC_HI      = 32'h0000_6ffc;

  logic        clk;
  logic        reset;
  logic [31:0] npc_in;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] F_PC;
  logic        fetch_valid;
  logic        F_exc_adel;
  logic        redirect;
  logic [15:0] stall_cnt;
  logic [31:0] fetch_cnt;

  f_pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .npc_in      (npc_in),
    .stall       (stall),
    .req         (req),
    .eret        (eret),
    .epc         (epc),
    .F_PC        (F_PC),
    .fetch_valid (fetch_valid),
    .F_exc_adel  (F_exc_adel),
    .redirect    (redirect),
    .stall_cnt   (stall_cnt),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: RUN and STALL behave identically from the
  // outside, so only "still booting" needs tracking.
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_redir;
  int unsigned m_scnt;
  logic [31:0] m_fcnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < C_PC_LO) || (a > C_PC_HI);
  endfunction

  task automatic model_reset();
    m_boot  = 1;
    m_pc    = C_RESET_PC;
    m_redir = 0;
    m_scnt  = 0;
    m_fcnt  = 0;
  endtask

  task automatic model_edge();
    if (m_boot) begin
      m_boot  = 0;
      m_redir = 0;
    end else begin
      m_redir = req || eret;
      if (req)       m_pc = C_HANDLER_PC;
      else if (eret) m_pc = epc;
      else if (stall) begin
        if (m_scnt < 65535) m_scnt = m_scnt + 1;
      end else         m_pc = npc_in;
      if (req || eret || !stall) m_fcnt = m_fcnt + 1;
    end
  endtask

  task automatic compare_all();
    check_val("F_PC",        F_PC,                  m_pc);
    check_val("fetch_valid", {31'd0, fetch_valid},  {31'd0, !m_boot});
    check_val("F_exc_adel",  {31'd0, F_exc_adel},   {31'd0, !m_boot && addr_bad(m_pc)});
    check_val("redirect",    {31'd0, redirect},     {31'd0, m_redir});
    check_val("stall_cnt",   {16'd0, stall_cnt},    m_scnt);
    check_val("fetch_cnt",   fetch_cnt,             m_fcnt);
  endtask

  // Inputs are applied just after a rising edge; outputs compared at negedge.
  task automatic drive(input logic [31:0] n, input bit s, input bit r, input bit e,
                       input logic [31:0] ep);
    npc_in = n; stall = s; req = r; eret = e; epc = ep;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  // Asserts reset between edges and checks the outputs before any edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  logic [31:0] rn;

  initial begin
    reset = 1'b0; npc_in = '0; stall = 0; req = 0; eret = 0; epc = '0;
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Sequential fetch up to 3010; BOOT cycle first.
    drive(32'h0, 0, 0, 0, 32'h0);
    check_val("boot_exit_pc", F_PC, 32'h3000);
    for (int i = 0; i < 8 && m_pc != 32'h3010; i++) begin
      drive(m_pc + 32'd4, 0, 0, 0, 32'h0);
      if (m_pc == 32'h300c) check_val("fcnt_after3", fetch_cnt, 32'd3);
    end

    // Three stall cycles at 3010.
    repeat (3) drive(m_pc + 32'd4, 1, 0, 0, 32'h0);
    check_val("stall_hold_pc", F_PC, 32'h3010);
    drive(m_pc + 32'd4, 0, 0, 0, 32'h0);
    check_val("after_stall_pc", F_PC, 32'h3014);
    check_val("stall_cnt3", {16'd0, stall_cnt}, 32'd3);

    // req and eret together while stalled.
    drive(m_pc + 32'd4, 1, 0, 0, 32'h0);
    drive(m_pc + 32'd4, 1, 1, 1, 32'h3040);
    check_val("req_pc", F_PC, 32'h4180);
    check_val("req_redir", {31'd0, redirect}, 32'd1);
    drive(m_pc + 32'd4, 0, 0, 0, 32'h0);
    check_val("redir_pulse", {31'd0, redirect}, 32'd0);

    // eret to a misaligned epc, then out-of-range npc.
    drive(m_pc + 32'd4, 0, 0, 1, 32'h3041);
    check_val("eret_pc", F_PC, 32'h3041);
    check_val("eret_adel", {31'd0, F_exc_adel}, 32'd1);
    drive(32'h7000, 0, 0, 0, 32'h0);
    check_val("oor_pc", F_PC, 32'h7000);
    check_val("oor_adel", {31'd0, F_exc_adel}, 32'd1);

    // Async reset in the middle of a stall with stall_cnt = 5.
    async_reset();
    drive(32'h0, 0, 0, 0, 32'h0);
    repeat (5) drive(m_pc + 32'd4, 1, 0, 0, 32'h0);
    check_val("scnt5", {16'd0, stall_cnt}, 32'd5);
    async_reset();
    check_val("arst_pc", F_PC, 32'h3000);
    check_val("arst_scnt", {16'd0, stall_cnt}, 32'd0);
    check_val("arst_fv", {31'd0, fetch_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       rn = $urandom;
        1:       rn = C_PC_LO + ($urandom_range(0, 32'h3fff) << 2);
        default: rn = m_pc + 32'd4;
      endcase
      if ($urandom_range(0, 299) == 0) async_reset();
      else drive(rn, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 24) == 0,
                 ($urandom_range(0, 3) == 0) ? $urandom
                                              : C_PC_LO + ($urandom_range(0, 32'h3fff) << 2));
    end

    // Saturation of the stall counter.
    repeat (70000) drive(m_pc + 32'd4, 1, 0, 0, 32'h0);
    check_val("scnt_sat", {16'd0, stall_cnt}, 32'h0000_ffff);
    drive(m_pc + 32'd4, 1, 0, 0, 32'h0);
    check_val("scnt_hold", {16'd0, stall_cnt}, 32'h0000_ffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
